// File: rtl/rr_select_arbiter_if.sv
// Request/select bundle between four requesters and the round-robin select arbiter.
// The master side drives requests and completion. The slave side returns the decoder select pair and grant status.
interface rr_select_arbiter_if #(
  parameter int unsigned CW = 4
);
  logic [3:0]    req;
  logic          done;
  logic          s0;
  logic          s1;
  logic          gnt_valid;
  logic [CW-1:0] hold_cnt;
  logic          timeout;

  modport master (
    output req, done,
    input  s0, s1, gnt_valid, hold_cnt, timeout
  );

  modport slave (
    input  req, done,
    output s0, s1, gnt_valid, hold_cnt, timeout
  );
endinterface

// File: rtl/rr_select_arbiter.sv
// Four-way round-robin arbiter that drives the 2-to-4 decoder select pair.
// A grant is held until done, request drop, or hold budget, and each grant is followed by one idle cycle.
module rr_select_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CW       = 4
) (
  input logic                clk,
  input logic                rst,
  rr_select_arbiter_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_last, w_last_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic [1:0]    w_pick;
  logic [CW-1:0] r_hold, w_hold_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          w_any_req;

  assign w_any_req = |bus.req;

  // Scan from r_last+1 to r_last. The loop runs downward so the nearest requester wins.
  always_comb begin
    w_pick = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[2'(r_last + 2'(k))]) w_pick = 2'(r_last + 2'(k));
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_sel_nxt     = r_sel;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_sel_nxt   = w_pick;
          w_hold_nxt  = '0;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A normal release outranks the hold limit, so done on the last cycle raises no timeout.
        if (bus.done || !bus.req[r_sel]) begin
          w_last_nxt  = r_sel;
          w_hold_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_hold == HOLD_LAST) begin
          w_last_nxt    = r_sel;
          w_hold_nxt    = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_hold_nxt = r_hold + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= 2'd3;
      r_sel     <= 2'd0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_sel     <= w_sel_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.s0        = r_sel[0];
  assign bus.s1        = r_sel[1];
  assign bus.gnt_valid = (r_state == ST_GRANT);
  assign bus.hold_cnt  = r_hold;
  assign bus.timeout   = r_timeout;
endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Four-requester round-robin arbiter that produces the 2-bit select pair driving the 2-to-4 decoder stage directly downstream. The granted requester index is presented on `s0` (LSB) and `s1` (MSB). The decoder's one-hot outputs then enable exactly one of four shared-resource users. The block holds a grant until the user finishes, drops its request, or exceeds a hold budget, then rotates priority.

## Interface
- `HOLD_MAX`, default 8: maximum cycles a single grant may be held (legal range 2..2^CW−1).
- `CW`, default 4: width of the hold counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req` in 4: request vector; `req[i]` high means requester i wants the resource.
- `done` in 1: the current grantee finished; qualified only while `gnt_valid` is high.
- `s0` out 1: select LSB, equal to granted index bit 0.
- `s1` out 1: select MSB, equal to granted index bit 1.
- `gnt_valid` out 1: `s0`/`s1` encode a live grant. Downstream decoder outputs are meaningful only while this is high.
- `hold_cnt` out CW: cycles elapsed in the current grant, 0 on the first grant cycle.
- `timeout` out 1: one-cycle pulse when a grant is revoked by the hold budget.

## Operation
- **State registers:** FSM state (IDLE, GRANT), `last` (2-bit index of the previous grantee), `sel` (2-bit current index), `hold_cnt`, `timeout`.
- **Reset values:** state=IDLE, `last`=3 (so requester 0 has first priority), `sel`=0, `s0`=0, `s1`=0, `gnt_valid`=0, `hold_cnt`=0, `timeout`=0.
- **IDLE:**
  - If `req`==0, stay in IDLE.
  - Otherwise, choose the first set bit scanning `last+1, last+2, last+3, last` modulo 4. Index arithmetic is 2-bit and wraps 3→0.
  - Load `sel`, set `hold_cnt`=0, go to GRANT.
- **GRANT:**
  - `gnt_valid`=1, `{s1,s0}`=`sel`.
  - Each cycle, evaluate the release conditions in this priority order:
    1. `done`=1, or `req[sel]`=0: normal release.
    2. `hold_cnt`==HOLD_MAX−1: forced release, with `timeout` pulsed high for the next cycle.
    3. Otherwise, `hold_cnt` increments by 1 and the state stays in GRANT.
  - On any release: `last`←`sel`, go to IDLE, `gnt_valid`←0, `hold_cnt`←0.
- **Gap cycle:** every grant is followed by at least one IDLE cycle with `gnt_valid`=0, so decoder outputs are never re-targeted back to back.
- **Outputs after release:** `s0`/`s1` retain `sel` while in IDLE and only change when a new grant is loaded. No glitching transitions occur on the select pair.
- **Simultaneous events:**
  - `done` and hold-limit in the same cycle: treated as normal release, no `timeout`.
  - `req` changes for non-granted requesters during GRANT: ignored until the next IDLE arbitration.
- **Starvation freedom:** a continuously asserted request is granted within 4 grants.
- **`done` outside GRANT:** ignored.

## Timing
- Arbitration latency: `req` sampled high at edge N in IDLE produces `gnt_valid`=1 and a valid `{s1,s0}` after edge N (visible in cycle N+1).
- Release latency: `done` sampled at edge M produces `gnt_valid`=0 after edge M. The earliest next grant is visible after edge M+1.
- Maximum grant length: HOLD_MAX cycles of `gnt_valid`=1. `timeout` is high for exactly the one cycle following the forced release edge, coincident with `gnt_valid`=0.
- Reset mid-grant: `rst` sampled high at any edge forces all reset values after that edge, regardless of `done`/`req`. The first post-reset arbitration favours requester 0.
- All outputs are registered; no combinational path from `req`/`done` to any output.

## Test plan
- **Reset, then single request:** `req`=4'b0100 → one cycle later `gnt_valid`=1, `{s1,s0}`=2'b10, `hold_cnt` counts 0,1,2…; assert `done` → `gnt_valid`=0 next cycle, `s1`/`s0` unchanged.
- **Round-robin rotation:** `req`=4'b1111 held, `done` pulsed on every grant's second cycle → grant order 0,1,2,3,0 with exactly one `gnt_valid`=0 cycle between grants.
- **Hold timeout (HOLD_MAX=8):** `req`=4'b0001 held, no `done` → `gnt_valid` high for exactly 8 cycles (`hold_cnt` 0..7), then `gnt_valid`=0 with `timeout`=1 for one cycle. Re-grant of index 0 follows, since it is the only requester.
- **Done at hold limit:** assert `done` in the cycle `hold_cnt`=7 → release, `timeout` stays 0.
- **Request withdrawal and rotation skip:** grant index 2 with `req`=4'b0101, then drop `req[2]` → release next edge. The next grant goes to index 0 (scan 3,0), not 2.
- **Reset mid-grant:** during a grant of index 3 (`hold_cnt`=3), pulse `rst` for one cycle with `req`=4'b1001 → after the reset edge all outputs are at reset values. The next grant is index 0, not 3.
